fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of `processor`. Generates the program counter, issues word reads to instruction memory over a request/grant/response interface, buffers returned words in a small prefetch queue and presents each instruction with its address (`counter`) to the core under a valid/ready handshake. Taken-branch redirects from execute flush in-flight and buffered fetches.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_queue.sv | 50 +++++
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Defaults for address/data width, queue depth and reset PC.
package fetch_pkg;

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  localparam int          DEF_AW       = 16;
  localparam int          DEF_DW       = 32;
  localparam int          DEF_DEPTH    = 2;
  localparam logic [15:0] DEF_RESET_PC = 16'h0000;

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO carrying {code, pc}, with a single-cycle flush.
// Wrap-around pointers plus an explicit occupancy count.
module fetch_queue #(
  parameter int            W       = 48,
  parameter int            DEPTH   = 2,
  parameter logic [W-1:0]  RST_VAL = '0,
  localparam int           PW      = $clog2(DEPTH),
  localparam int           CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RST_VAL;
      end
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= wdata;
        wp      <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem[rp];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, credit-limited imem reads, prefetch queue.
// Define FETCH_PERF_EN to add saturating perf_fetched/perf_dropped counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int            AW       = DEF_AW,
  parameter int            DW       = DEF_DW,
  parameter int            DEPTH    = DEF_DEPTH,
  parameter logic [AW-1:0] RESET_PC = AW'(DEF_RESET_PC)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [DW-1:0] imem_rdata,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [DW-1:0] inst_code,
`ifdef FETCH_PERF_EN
  output logic [31:0]   perf_fetched,
  output logic [31:0]   perf_dropped,
`endif
  output logic [AW-1:0] counter
);

  localparam int            CW  = $clog2(DEPTH + 1);
  localparam logic [CW:0]   CAP = (CW + 1)'(DEPTH);

  state_t        state, state_n;
  logic [AW-1:0] fetch_pc, fetch_pc_n;
  logic [CW-1:0] outstanding, outst_n;
  logic [CW-1:0] discard, discard_n;
  logic [CW-1:0] q_count;
  logic [CW:0]   credit;
  logic          live;
  logic          gnt_ok, rsp_ok, drop, push, pop;
  logic [AW-1:0] rsp_pc;
  logic [DW+AW-1:0] q_head;

  assign pop        = inst_valid && inst_ready;
  assign inst_valid = (q_count != '0);

  // A head leaving this cycle frees a slot, keeping full rate at DEPTH 2
  assign credit   = {1'b0, outstanding} + {1'b0, q_count}
                  - {{CW{1'b0}}, pop};
  assign imem_req  = live && (credit < CAP);
  assign imem_addr = fetch_pc;

  assign gnt_ok = imem_req && imem_gnt;
  assign rsp_ok = imem_rvalid && (outstanding != '0);
  assign drop   = rsp_ok && (redirect || state == FLUSH);
  assign push   = rsp_ok && !drop;

  // Kept reads are contiguous and end just below fetch_pc
  assign rsp_pc = fetch_pc - AW'(outstanding - discard);

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    discard_n  = discard;
    outst_n    = outstanding + CW'(gnt_ok) - CW'(rsp_ok);
    if (redirect) begin
      fetch_pc_n = redirect_pc;
      discard_n  = outst_n;
    end else begin
      if (gnt_ok) fetch_pc_n = fetch_pc + 1'b1;
      if (rsp_ok && state == FLUSH) discard_n = discard - 1'b1;
    end
    unique case (state)
      RUN:   if (discard_n != '0) state_n = FLUSH;
      FLUSH: if (discard_n == '0) state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      live        <= 1'b0;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      outstanding <= outst_n;
      discard     <= discard_n;
      live        <= 1'b1;
    end
  end

  fetch_queue #(
    .W       (DW + AW),
    .DEPTH   (DEPTH),
    .RST_VAL ({{DW{1'b0}}, RESET_PC})
  ) u_queue (
    .clk   (clk),
    .rst_n (reset),
    .flush (redirect),
    .push  (push),
    .wdata ({imem_rdata, rsp_pc}),
    .pop   (pop),
    .rdata (q_head),
    .count (q_count)
  );

  assign inst_code = q_head[DW+AW-1:AW];
  assign counter   = q_head[AW-1:0];

`ifdef FETCH_PERF_EN
  logic [CW-1:0] flushed;
  assign flushed = redirect ? q_count - CW'(pop) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      perf_fetched <= sat_add(perf_fetched, 32'(pop));
      perf_dropped <= sat_add(perf_dropped,
                              32'(flushed) + 32'(drop));
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirects, reset, PC wrap.
// A second instance starts at 16'hFFFE to cover address wrap-around.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        imem_req, imem_gnt, imem_rvalid;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_code;
  logic [15:0] counter;

  logic        w_req, w_rvalid, w_valid;
  logic [15:0] w_addr, w_counter;
  logic [31:0] w_rdata, w_code;

`ifdef FETCH_PERF_EN
  logic [31:0] pf, pd, w_pf, w_pd;
`endif

  int          vecs = 0;
  int          errs = 0;
  int          gnt_total = 0;
  int          pops = 0;
  logic        rsp_en;
  logic [15:0] pend [$];
  logic [15:0] exp_pc;
  logic        wv;
  logic [15:0] wa;

  fetch_unit #(
    .AW(16), .DW(32), .DEPTH(2), .RESET_PC(16'h0000)
  ) dut (
    .clk         (clk),
`ifdef FETCH_PERF_EN
    .perf_fetched(pf),
    .perf_dropped(pd),
`endif
    .reset       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_code   (inst_code),
    .counter     (counter)
  );

  fetch_unit #(
    .AW(16), .DW(32), .DEPTH(2), .RESET_PC(16'hFFFE)
  ) u_wrap (
    .clk         (clk),
`ifdef FETCH_PERF_EN
    .perf_fetched(w_pf),
    .perf_dropped(w_pd),
`endif
    .reset       (rst_n),
    .imem_req    (w_req),
    .imem_addr   (w_addr),
    .imem_gnt    (1'b1),
    .imem_rvalid (w_rvalid),
    .imem_rdata  (w_rdata),
    .redirect    (1'b0),
    .redirect_pc (16'h0000),
    .inst_valid  (w_valid),
    .inst_ready  (1'b1),
    .inst_code   (w_code),
    .counter     (w_counter)
  );

  // In-order memory, data = {~addr, addr}; rsp_en holds responses back
  always @(negedge clk) begin
    if (!rst_n) begin
      pend.delete();
      imem_rvalid <= 1'b0;
      gnt_total = 0;
    end else begin
      if (rsp_en && pend.size() > 0) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= {~pend[0], pend[0]};
        void'(pend.pop_front());
      end else begin
        imem_rvalid <= 1'b0;
      end
      if (imem_req && imem_gnt) begin
        pend.push_back(imem_addr);
        gnt_total++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      w_rvalid <= 1'b0;
      wv = 1'b0;
      wa = '0;
    end else begin
      w_rvalid <= wv;
      w_rdata  <= {~wa, wa};
      wv = w_req;
      wa = w_addr;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) pops = 0;
    else if (inst_valid && inst_ready) pops++;
  end

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vecs++;
    if (imem_req !== 1'b0) begin
      errs++; $display("FAIL rst_req: got %b want 0", imem_req);
    end
    vecs++;
    if (imem_addr !== 16'h0000) begin
      errs++; $display("FAIL rst_addr: got %h want 0000", imem_addr);
    end
    vecs++;
    if (inst_valid !== 1'b0) begin
      errs++; $display("FAIL rst_valid: got %b want 0", inst_valid);
    end
    vecs++;
    if (inst_code !== 32'h0) begin
      errs++; $display("FAIL rst_code: got %h want 0", inst_code);
    end
    vecs++;
    if (counter !== 16'h0000) begin
      errs++; $display("FAIL rst_counter: got %h want 0000", counter);
    end
    vecs++;
    if (w_counter !== 16'hFFFE) begin
      errs++; $display("FAIL rst_wcounter: got %h want fffe", w_counter);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vecs++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      errs++;
      $display("FAIL first_req: got %b/%h want 1/0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream;
    int seen;
    seen = 0;
    exp_pc = 16'h0000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (inst_valid) begin
        vecs++;
        if (counter !== exp_pc || inst_code !== {~exp_pc, exp_pc}) begin
          errs++;
          $display("FAIL stream: got %h/%h want %h", counter, inst_code, exp_pc);
        end
        exp_pc++;
        seen++;
      end
    end
    vecs++;
    if (seen != 19) begin
      errs++; $display("FAIL throughput: got %0d want 19", seen);
    end
  endtask

  task automatic test_stall;
    @(posedge clk); #1 inst_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      vecs++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b1) begin
        errs++;
        $display("FAIL stall: got req %b valid %b want 0/1", imem_req, inst_valid);
      end
    end
    vecs++;
    if (gnt_total - pops != 2) begin
      errs++; $display("FAIL stall_reads: got %0d want 2", gnt_total - pops);
    end
    vecs++;
    if (counter !== exp_pc) begin
      errs++; $display("FAIL stall_head: got %h want %h", counter, exp_pc);
    end
    @(posedge clk); #1 inst_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vecs++;
      if (inst_valid !== 1'b1 || counter !== exp_pc) begin
        errs++;
        $display("FAIL resume: got %b/%h want 1/%h", inst_valid, counter, exp_pc);
      end
      exp_pc++;
    end
  endtask

  task automatic test_redirect_outstanding;
    int seen;
    logic [31:0] pd0;
    pd0 = '0;
    @(posedge clk); #1 rsp_en = 1'b0;
    repeat (4) @(negedge clk);
`ifdef FETCH_PERF_EN
    pd0 = pd;
`endif
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 16'h0040;
    @(posedge clk); #1 redirect = 1'b0; rsp_en = 1'b1;
    @(negedge clk);
    vecs++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 16'h0040) begin
      errs++;
      $display("FAIL redir_out: got v%b r%b %h want v0 r0 0040",
               inst_valid, imem_req, imem_addr);
    end
    exp_pc = 16'h0040;
    seen = 0;
    for (int i = 0; i < 12 && seen < 4; i++) begin
      @(negedge clk);
      if (inst_valid) begin
        vecs++;
        if (counter !== exp_pc || inst_code !== {~exp_pc, exp_pc}) begin
          errs++;
          $display("FAIL redir_seq: got %h/%h want %h", counter, inst_code, exp_pc);
        end
        exp_pc++;
        seen++;
      end
    end
    vecs++;
    if (seen != 4) begin
      errs++; $display("FAIL redir_timeout: got %0d want 4", seen);
    end
`ifdef FETCH_PERF_EN
    vecs++;
    if (pd - pd0 !== 32'd2) begin
      errs++; $display("FAIL perf_drop_a: got %0d want 2", pd - pd0);
    end
`endif
  endtask

  task automatic test_redirect_coincident;
    logic [31:0] pd0;
    pd0 = '0;
`ifdef FETCH_PERF_EN
    pd0 = pd;
`endif
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 16'h0100;
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    vecs++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0100) begin
      errs++;
      $display("FAIL coinc_req: got v%b r%b %h want v0 r1 0100",
               inst_valid, imem_req, imem_addr);
    end
    @(negedge clk);
    vecs++;
    if (inst_valid !== 1'b0) begin
      errs++; $display("FAIL coinc_gap: got %b want 0", inst_valid);
    end
    exp_pc = 16'h0100;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vecs++;
      if (inst_valid !== 1'b1 || counter !== exp_pc) begin
        errs++;
        $display("FAIL coinc_seq: got %b/%h want 1/%h", inst_valid, counter, exp_pc);
      end
      exp_pc++;
    end
`ifdef FETCH_PERF_EN
    vecs++;
    if (pd - pd0 !== 32'd2) begin
      errs++; $display("FAIL perf_drop_b: got %0d want 2", pd - pd0);
    end
    @(posedge clk); #1;
    vecs++;
    if (pf !== 32'(pops)) begin
      errs++; $display("FAIL perf_fetch: got %0d want %0d", pf, pops);
    end
`endif
  endtask

  task automatic test_reset_flush;
    int seen;
    @(posedge clk); #1 rsp_en = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 16'h0200;
    @(posedge clk); #1 redirect = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if (imem_req !== 1'b0 || imem_addr !== 16'h0000) begin
      errs++;
      $display("FAIL async_req: got %b/%h want 0/0000", imem_req, imem_addr);
    end
    vecs++;
    if (inst_valid !== 1'b0 || counter !== 16'h0000 || inst_code !== 32'h0) begin
      errs++;
      $display("FAIL async_out: got %b/%h/%h want 0/0000/0",
               inst_valid, counter, inst_code);
    end
    rsp_en = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    exp_pc = 16'h0000;
    seen = 0;
    for (int i = 0; i < 12 && seen < 5; i++) begin
      @(negedge clk);
      if (inst_valid) begin
        vecs++;
        if (counter !== exp_pc) begin
          errs++; $display("FAIL restart: got %h want %h", counter, exp_pc);
        end
        exp_pc++;
        seen++;
      end
    end
    vecs++;
    if (seen != 5) begin
      errs++; $display("FAIL restart_timeout: got %0d want 5", seen);
    end
  endtask

  task automatic test_wrap;
    int seen;
    logic [15:0] e;
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    e = 16'hFFFE;
    seen = 0;
    for (int i = 0; i < 12 && seen < 4; i++) begin
      @(negedge clk);
      if (w_valid) begin
        vecs++;
        if (w_counter !== e || w_code !== {~e, e}) begin
          errs++;
          $display("FAIL wrap: got %h/%h want %h", w_counter, w_code, e);
        end
        e++;
        seen++;
      end
    end
    vecs++;
    if (seen != 4) begin
      errs++; $display("FAIL wrap_timeout: got %0d want 4", seen);
    end
  endtask

  initial begin
    imem_gnt    = 1'b1;
    rsp_en      = 1'b1;
    inst_ready  = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    test_reset;
    test_stream;
    test_stall;
    test_redirect_outstanding;
    test_redirect_coincident;
    test_reset_flush;
    test_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
